// File: rtl/conf_channel_deserializer.sv
// Assembles Nchunks consecutive Nin-wide config transfers, little-endian, into one
// Nout-wide word held in an output register so the next word can fill behind a stall.
module conf_channel_deserializer #(
  parameter  int Nin     = 16,
  parameter  int Nout    = 40,
  localparam int Nchunks = (Nout + Nin - 1) / Nin,
  localparam int IdxW    = $clog2(Nchunks + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_v,
  input  logic [Nin-1:0]  in_d,
  output logic            in_a,
  output logic            out_v,
  output logic [Nout-1:0] out_d,
  input  logic            out_a,
  output logic [IdxW-1:0] chunk_idx
);

  localparam int LastW = Nout - (Nchunks - 1) * Nin;

  logic [Nout-1:0] asm_q;
  logic [Nout-1:0] merged;
  logic            last_chunk;
  logic            accept;

  assign last_chunk = (chunk_idx == IdxW'(Nchunks - 1));

  // The final chunk may only enter when the output register is free this cycle,
  // so in_a is combinational on out_a.
  assign in_a   = in_v & (~last_chunk | ~out_v | out_a);
  assign accept = in_v & in_a;

  // Current chunk overlays its slot; the final slot keeps only its low LastW bits.
  for (genvar k = 0; k < Nchunks; k++) begin : g_slot
    localparam int W = (k == Nchunks - 1) ? LastW : Nin;
    assign merged[k*Nin +: W] = (chunk_idx == IdxW'(k)) ? in_d[W-1:0] : asm_q[k*Nin +: W];
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the assembly buffer is reset along with control so a discarded
      // partial word can never leak into a later output.
      asm_q     <= '0;
      chunk_idx <= '0;
      out_v     <= 1'b0;
      out_d     <= '0;
    end else begin
      if (accept) begin
        if (last_chunk) begin
          out_d     <= merged;
          chunk_idx <= '0;
        end else begin
          asm_q     <= merged;
          chunk_idx <= chunk_idx + IdxW'(1);
        end
      end
      if (accept && last_chunk) begin
        out_v <= 1'b1;
      end else if (out_a) begin
        out_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conf_channel_deserializer.sv
// Bench for conf_channel_deserializer: directed cycle table, reset corner sequences,
// and randomized handshakes on a 16->40 and a 16->16 instance against a word-level model.
module tb_conf_channel_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_v, in_a, out_v, out_a;
  logic [15:0] in_d;
  logic [39:0] out_d;
  logic [1:0]  idx;

  logic        in1_v, in1_a, out1_v, out1_a;
  logic [15:0] in1_d, out1_d;
  logic [0:0]  idx1;

  conf_channel_deserializer #(.Nin(16), .Nout(40)) dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .out_v(out_v), .out_d(out_d), .out_a(out_a),
    .chunk_idx(idx)
  );

  conf_channel_deserializer #(.Nin(16), .Nout(16)) dut1 (
    .clk(clk), .reset(reset),
    .in_v(in1_v), .in_d(in1_d), .in_a(in1_a),
    .out_v(out1_v), .out_d(out1_d), .out_a(out1_a),
    .chunk_idx(idx1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(string name, string detail);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  // One cycle: drive after the edge, return at the following negedge for sampling.
  task automatic step(logic r, logic v, logic [15:0] d, logic oa);
    @(posedge clk);
    #1;
    reset = r; in_v = v; in_d = d; out_a = oa;
    @(negedge clk);
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        oa;
    logic        ea;
    logic        ev;
    logic [39:0] ed;
    logic [1:0]  ei;
  } vec_t;

  vec_t tbl [15];

  // Word-level reference: expected words in order, plus count of accepted chunks.
  logic [39:0] exp_q  [$];
  logic [15:0] exp1_q [$];
  logic [39:0] exp_w;
  logic [15:0] exp1_w;
  int          acc_cnt = 0;
  logic        rand_on = 1'b0;
  logic        cons_on = 1'b0;

  always @(negedge clk) begin
    if (rand_on) begin
      check("rand_chunk_idx", 64'(idx), 64'(acc_cnt % 3));
      check("rand_in_a_rule", 64'(in_a),
            64'(in_v && ((acc_cnt % 3) != 2 || !out_v || out_a)));
      if (in_v && in_a) acc_cnt++;
      if (out_v && out_a) begin
        if (exp_q.size() == 0) begin
          fail_msg("rand_word", $sformatf("got spurious word 0x%0h, expected none", out_d));
        end else begin
          exp_w = exp_q.pop_front();
          check("rand_word", 64'(out_d), 64'(exp_w));
        end
      end
      check("rand1_in_a_rule", 64'(in1_a), 64'(in1_v && (!out1_v || out1_a)));
      if (out1_v && out1_a) begin
        if (exp1_q.size() == 0) begin
          fail_msg("rand1_word", $sformatf("got spurious word 0x%0h, expected none", out1_d));
        end else begin
          exp1_w = exp1_q.pop_front();
          check("rand1_word", 64'(out1_d), 64'(exp1_w));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in_v = 1'b0; in_d = '0; out_a = 1'b0;
    in1_v = 1'b0; in1_d = '0; out1_a = 1'b0;

    // Rows: drive {v, d, out_a}; expect {in_a, out_v, out_d, chunk_idx} in that cycle.
    tbl[0]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 40'h0,          2'd0};
    tbl[1]  = '{1'b1, 16'h5678, 1'b1, 1'b1, 1'b0, 40'h0,          2'd1};
    tbl[2]  = '{1'b1, 16'hAB9C, 1'b1, 1'b1, 1'b0, 40'h0,          2'd2};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 40'h9C56781234, 2'd0};
    tbl[4]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 40'h9C56781234, 2'd0};
    tbl[5]  = '{1'b1, 16'h5678, 1'b0, 1'b1, 1'b0, 40'h9C56781234, 2'd1};
    tbl[6]  = '{1'b1, 16'hAB9C, 1'b0, 1'b1, 1'b0, 40'h9C56781234, 2'd2};
    tbl[7]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 40'h9C56781234, 2'd0};
    tbl[8]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 40'h9C56781234, 2'd1};
    tbl[9]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 40'h9C56781234, 2'd2};
    tbl[10] = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 40'h9C56781234, 2'd2};
    tbl[11] = '{1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 40'h9C56781234, 2'd2};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 40'h3322221111, 2'd0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 40'h3322221111, 2'd0};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 40'h3322221111, 2'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_v",  64'(out_v),  64'(0));
    check("reset_out_d",  64'(out_d),  64'(0));
    check("reset_idx",    64'(idx),    64'(0));
    check("reset1_out_v", 64'(out1_v), 64'(0));
    check("reset1_idx",   64'(idx1),   64'(0));

    for (int i = 0; i < 15; i++) begin
      step(1'b0, tbl[i].v, tbl[i].d, tbl[i].oa);
      check($sformatf("tbl%0d_in_a", i),  64'(in_a),  64'(tbl[i].ea));
      check($sformatf("tbl%0d_out_v", i), 64'(out_v), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_out_d", i), 64'(out_d), 64'(tbl[i].ed));
      check($sformatf("tbl%0d_idx", i),   64'(idx),   64'(tbl[i].ei));
    end

    // Reset in the middle of a word discards the partial chunks.
    step(1'b0, 1'b1, 16'hAAAA, 1'b1); check("midrst_idx0", 64'(idx), 64'(0));
    step(1'b0, 1'b1, 16'hBBBB, 1'b1); check("midrst_idx1", 64'(idx), 64'(1));
    step(1'b1, 1'b0, 16'h0000, 1'b1); check("midrst_idx2", 64'(idx), 64'(2));
    step(1'b0, 1'b1, 16'h0001, 1'b1);
    check("midrst_after_out_v", 64'(out_v), 64'(0));
    check("midrst_after_idx",   64'(idx),   64'(0));
    check("midrst_after_in_a",  64'(in_a),  64'(1));
    step(1'b0, 1'b1, 16'h0002, 1'b1); check("midrst_c1_out_v", 64'(out_v), 64'(0));
    step(1'b0, 1'b1, 16'h0003, 1'b1); check("midrst_c2_out_v", 64'(out_v), 64'(0));
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("midrst_word_v", 64'(out_v), 64'(1));
    check("midrst_word_d", 64'(out_d), 64'h0300020001);
    step(1'b0, 1'b0, 16'h0000, 1'b1); check("midrst_word_once", 64'(out_v), 64'(0));

    // Reset while a word is stalled on the output discards it.
    step(1'b0, 1'b1, 16'h7777, 1'b0);
    step(1'b0, 1'b1, 16'h8888, 1'b0);
    step(1'b0, 1'b1, 16'h9999, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    check("stallrst_pre_v", 64'(out_v), 64'(1));
    check("stallrst_pre_d", 64'(out_d), 64'h9988887777);
    step(1'b1, 1'b0, 16'h0000, 1'b0); check("stallrst_during_v", 64'(out_v), 64'(1));
    step(1'b0, 1'b1, 16'h4444, 1'b0);
    check("stallrst_after_v",    64'(out_v), 64'(0));
    check("stallrst_after_idx",  64'(idx),   64'(0));
    check("stallrst_after_in_a", 64'(in_a),  64'(1));
    step(1'b0, 1'b1, 16'h5555, 1'b0); check("stallrst_idx1", 64'(idx), 64'(1));
    step(1'b0, 1'b1, 16'h6666, 1'b1); check("stallrst_in_a2", 64'(in_a), 64'(1));
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("stallrst_next_v", 64'(out_v), 64'(1));
    check("stallrst_next_d", 64'(out_d), 64'h6655554444);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("stallrst_end_v",   64'(out_v), 64'(0));
    check("stallrst_end_idx", 64'(idx),   64'(0));

    // Randomized traffic on both instances.
    @(posedge clk);
    #1;
    rand_on = 1'b1;
    cons_on = 1'b1;
    fork
      begin
        while (cons_on) begin
          @(posedge clk);
          #1;
          out_a  = ($urandom_range(0, 2) != 0);
          out1_a = ($urandom_range(0, 2) != 0);
        end
      end
    join_none

    fork
      begin : prod0
        logic [15:0] ch [3];
        int          to;
        for (int w = 0; w < 1000; w++) begin
          for (int k = 0; k < 3; k++) ch[k] = 16'($urandom);
          exp_q.push_back({ch[2][7:0], ch[1], ch[0]});
          for (int k = 0; k < 3; k++) begin
            while ($urandom_range(0, 3) == 0) begin
              in_v = 1'b0;
              @(posedge clk);
              #1;
            end
            in_v = 1'b1;
            in_d = ch[k];
            @(negedge clk);
            to = 0;
            while (!in_a && to < 200) begin
              @(negedge clk);
              to++;
            end
            if (!in_a) fail_msg("rand_in_timeout", "in_a stayed 0, expected 1 within 200 cycles");
            @(posedge clk);
            #1;
          end
        end
        in_v = 1'b0;
      end
      begin : prod1
        logic [15:0] dat;
        int          to1;
        for (int w = 0; w < 400; w++) begin
          dat = 16'($urandom);
          exp1_q.push_back(dat);
          while ($urandom_range(0, 3) == 0) begin
            in1_v = 1'b0;
            @(posedge clk);
            #1;
          end
          in1_v = 1'b1;
          in1_d = dat;
          @(negedge clk);
          to1 = 0;
          while (!in1_a && to1 < 200) begin
            @(negedge clk);
            to1++;
          end
          if (!in1_a) fail_msg("rand1_in_timeout", "in_a stayed 0, expected 1 within 200 cycles");
          @(posedge clk);
          #1;
        end
        in1_v = 1'b0;
      end
    join

    for (int d = 0; d < 1000 && (exp_q.size() != 0 || exp1_q.size() != 0); d++) @(posedge clk);
    if (exp_q.size() != 0)
      fail_msg("rand_drain", $sformatf("%0d words outstanding, expected 0", exp_q.size()));
    if (exp1_q.size() != 0)
      fail_msg("rand1_drain", $sformatf("%0d words outstanding, expected 0", exp1_q.size()));
    repeat (4) @(posedge clk);
    #1;
    rand_on = 1'b0;
    cons_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
